adder_pipe_nbit: RTL and testbench

- Parametrised successor of the team's 1-bit full adder: a WIDTH-bit adder/subtractor built from CHUNK-bit full-adder slices.
- Split over STAGES register stages, with the carry registered between stages.
- Valid/ready handshake on input and output; full-throughput, back-pressure-aware.
- Sits in the arithmetic datapath as the reusable multi-bit add/sub primitive for the ALU and accumulator blocks.

---
 rtl/adder_pipe_pkg.sv | 26 ++
 rtl/adder_pipe_nbit_chunk.sv | 31 +++
 rtl/adder_pipe_nbit.sv | 153 +++++++++++++++
 tb/tb_adder_pipe_nbit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pipe_pkg.sv
// Shared types and constant helpers for the pipelined add/sub primitive.
package adder_pipe_pkg;

    localparam int MAX_W = 64;

    // Sideband travelling alongside each stage's partial result.
    typedef struct packed {
        logic valid;
        logic sub;
        logic sat;
        logic carry;
    } side_t;

    function automatic int chunk_w(input int width, input int stages);
        return width / stages;
    endfunction

    function automatic logic [MAX_W-1:0] sat_pos(input int width);
        return {MAX_W{1'b1}} >> (MAX_W - width + 1);
    endfunction

    function automatic logic [MAX_W-1:0] sat_neg(input int width);
        return {{(MAX_W-1){1'b0}}, 1'b1} << (width - 1);
    endfunction

endpackage

// File: rtl/adder_pipe_nbit_chunk.sv
// CHUNK-bit combinational ripple adder; also exposes the carry into its MSB
// so the last stage can derive signed overflow.
module adder_chunk
    import adder_pipe_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         c_i,
    output logic [W-1:0] s_o,
    output logic         c_o,
    output logic         c_msb_o
);

    logic [W:0] c;

    always_comb begin
        c    = '0;
        s_o  = '0;
        c[0] = c_i;
        for (int i = 0; i < W; i++) begin
            s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
            c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
        end
    end

    assign c_o     = c[W];
    assign c_msb_o = c[W-1];

endmodule

// File: rtl/adder_pipe_nbit.sv
// WIDTH-bit pipelined adder/subtractor, STAGES chunks with registered carry.
// Optional signed saturation enabled by defining ADDER_PIPE_SAT_EN.
module adder_pipe_nbit
    import adder_pipe_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C0,
    input  logic             SUB,
`ifdef ADDER_PIPE_SAT_EN
    input  logic             SAT,
`endif
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [WIDTH-1:0] F,
    output logic             C1,
    output logic             OVF,
    output logic             OUT_VALID,
    input  logic             OUT_READY
);

    localparam int CHUNK = chunk_w(WIDTH, STAGES);
    localparam logic [MAX_W-1:0] SAT_P_FULL = sat_pos(WIDTH);
    localparam logic [MAX_W-1:0] SAT_N_FULL = sat_neg(WIDTH);
    localparam logic [WIDTH-1:0] SAT_P = SAT_P_FULL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SAT_N = SAT_N_FULL[WIDTH-1:0];

    logic             en;
    logic             sat_in;
    side_t            sd_in;
    logic             vld_q;
    logic [WIDTH-1:0] f_q;
    logic             c1_q;
    logic             ovf_q;

`ifdef ADDER_PIPE_SAT_EN
    assign sat_in = SAT;
`else
    assign sat_in = 1'b0;
`endif

    // Whole pipeline advances together; only a held output stalls it.
    assign en       = !vld_q || OUT_READY;
    assign IN_READY = en;

    // Subtraction enters as A + ~B + ~C0; B inversion happens per chunk.
    assign sd_in = '{valid: IN_VALID, sub: SUB, sat: sat_in, carry: C0 ^ SUB};

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int HI = WIDTH - k * CHUNK;
        localparam int LO = k * CHUNK;

        logic [HI-1:0]       a_s;
        logic [HI-1:0]       b_s;
        side_t               sd_s;
        logic [CHUNK-1:0]    s;
        logic                co;
        logic                cmsb;
        logic [LO+CHUNK-1:0] res;

        if (k == 0) begin : g_src
            assign a_s  = A;
            assign b_s  = B;
            assign sd_s = sd_in;
            assign res  = s;
        end else begin : g_src
            assign a_s  = g_stg[k-1].g_mid.a_q;
            assign b_s  = g_stg[k-1].g_mid.b_q;
            assign sd_s = g_stg[k-1].g_mid.sd_q;
            assign res  = {s, g_stg[k-1].g_mid.f_q};
        end

        adder_chunk #(.W(CHUNK)) u_chunk (
            .a_i     (a_s[CHUNK-1:0]),
            .b_i     (b_s[CHUNK-1:0] ^ {CHUNK{sd_s.sub}}),
            .c_i     (sd_s.carry),
            .s_o     (s),
            .c_o     (co),
            .c_msb_o (cmsb)
        );

        if (k < STAGES - 1) begin : g_mid
            // Operands shrink and the result grows by one chunk per stage.
            logic [HI-CHUNK-1:0] a_q;
            logic [HI-CHUNK-1:0] b_q;
            logic [LO+CHUNK-1:0] f_q;
            side_t               sd_q;
            logic                unused_cmsb;

            assign unused_cmsb = cmsb;

            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    a_q  <= '0;
                    b_q  <= '0;
                    f_q  <= '0;
                    sd_q <= '0;
                end else if (en) begin
                    sd_q.valid <= sd_s.valid;
                    if (sd_s.valid) begin
                        a_q        <= a_s[HI-1:CHUNK];
                        b_q        <= b_s[HI-1:CHUNK];
                        f_q        <= res;
                        sd_q.sub   <= sd_s.sub;
                        sd_q.sat   <= sd_s.sat;
                        sd_q.carry <= co;
                    end
                end
            end
        end else begin : g_last
            logic             ovf_d;
            logic [WIDTH-1:0] f_d;

            assign ovf_d = cmsb ^ co;

            // On overflow both effective operands share A's sign, so A's MSB
            // gives the direction to clamp towards.
            always_comb begin
                f_d = res;
                if (sd_s.sat && ovf_d) begin
                    f_d = a_s[HI-1] ? SAT_N : SAT_P;
                end
            end

            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    vld_q <= 1'b0;
                    f_q   <= '0;
                    c1_q  <= 1'b0;
                    ovf_q <= 1'b0;
                end else if (en) begin
                    vld_q <= sd_s.valid;
                    if (sd_s.valid) begin
                        f_q   <= f_d;
                        c1_q  <= co;
                        ovf_q <= ovf_d;
                    end
                end
            end
        end
    end

    assign F         = f_q;
    assign C1        = c1_q;
    assign OVF       = ovf_q;
    assign OUT_VALID = vld_q;

endmodule

// File: tb/tb_adder_pipe_nbit.sv
// Directed bench for adder_pipe_nbit (WIDTH=8, STAGES=2) with an in-order scoreboard.
module tb_adder_pipe_nbit;

    localparam int W = 8;
    localparam int S = 2;

    logic         CLK = 1'b0;
    logic         RST_N = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         C0 = 1'b0;
    logic         SUB = 1'b0;
    logic         IN_VALID = 1'b0;
    logic         OUT_READY = 1'b1;
`ifdef ADDER_PIPE_SAT_EN
    logic         SAT = 1'b0;
`endif
    logic         IN_READY;
    logic [W-1:0] F;
    logic         C1;
    logic         OVF;
    logic         OUT_VALID;

    typedef struct {
        logic [W-1:0] f;
        logic         c1;
        logic         ovf;
        int           id;
    } exp_t;

    exp_t sb[$];
    int   chk_cnt = 0;
    int   pass_cnt = 0;
    int   id_cnt = 0;

    always #5 CLK = ~CLK;

    adder_pipe_nbit #(.WIDTH(W), .STAGES(S)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .A         (A),
        .B         (B),
        .C0        (C0),
        .SUB       (SUB),
`ifdef ADDER_PIPE_SAT_EN
        .SAT       (SAT),
`endif
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .F         (F),
        .C1        (C1),
        .OVF       (OVF),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push_exp(input logic [W-1:0] f, input logic c1, input logic ovf);
        sb.push_back('{f: f, c1: c1, ovf: ovf, id: id_cnt});
        id_cnt++;
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic c0, input logic sub);
        exp_t         e;
        logic [W-1:0] bb;
        logic [W:0]   r;
        bb    = sub ? ~b : b;
        r     = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sub ? !c0 : c0)};
        e.f   = r[W-1:0];
        e.c1  = r[W];
        e.ovf = (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]);
        e.id  = 0;
        return e;
    endfunction

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c0,
                        input logic sub, input logic sat, input logic [W-1:0] ef,
                        input logic ec1, input logic eovf);
        @(posedge CLK);
        #1;
        A = a; B = b; C0 = c0; SUB = sub; IN_VALID = 1'b1;
`ifdef ADDER_PIPE_SAT_EN
        SAT = sat;
`else
        if (sat) IN_VALID = 1'b1;
`endif
        push_exp(ef, ec1, eovf);
    endtask

    task automatic idle();
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge CLK);
        @(posedge CLK);
        #1;
        chk(tag, sb.size(), 0);
    endtask

    // Output monitor: in-order scoreboard plus stability while stalled.
    initial begin
        exp_t       e;
        bit         held = 1'b0;
        logic [9:0] held_v = '0;
        forever begin
            @(negedge CLK);
            if (!RST_N) begin
                held = 1'b0;
            end else begin
                if (held) chk("hold_out", {F, C1, OVF}, held_v);
                held   = OUT_VALID && !OUT_READY;
                held_v = {F, C1, OVF};
                if (OUT_VALID && OUT_READY) begin
                    if (sb.size() == 0) begin
                        chk("spurious_out", OUT_VALID, 0);
                    end else begin
                        e = sb.pop_front();
                        chk($sformatf("result#%0d", e.id), {F, C1, OVF}, {e.f, e.c1, e.ovf});
                    end
                end
            end
        end
    end

    initial begin
        exp_t         e;
        int           idx;
        int           cyc;
        logic [W-1:0] ra, rb;
        logic         rc, rs;

        #12;
        chk("rst_out_valid", OUT_VALID, 0);
        chk("rst_f", F, 0);
        chk("rst_c1_ovf", {C1, OVF}, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        chk("rst_in_ready", IN_READY, 1);

        send(8'h3C, 8'h05, 1'b1, 1'b0, 1'b0, 8'h42, 1'b0, 1'b0);
        send(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        send(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        send(8'h10, 8'h20, 1'b0, 1'b1, 1'b0, 8'hF0, 1'b0, 1'b0);
        send(8'h80, 8'h01, 1'b0, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1);
        send(8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 8'hFE, 1'b1, 1'b0);
        send(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0);
        send(8'h05, 8'h03, 1'b1, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0);
        send(8'h0F, 8'h01, 1'b0, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
        idle();
        drain("drain_directed");

        // Six-beat stream with the consumer stalled for cycles 3..5.
        idx = 0;
        cyc = 0;
        ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom); rs = 1'($urandom);
        while (idx < 6 && cyc < 40) begin
            @(posedge CLK);
            #1;
            OUT_READY = !(cyc >= 3 && cyc <= 5);
            A = ra; B = rb; C0 = rc; SUB = rs; IN_VALID = 1'b1;
            @(negedge CLK);
            if (cyc >= 3 && cyc <= 5) chk("stall_in_ready", IN_READY, 0);
            if (IN_READY) begin
                e = model(ra, rb, rc, rs);
                push_exp(e.f, e.c1, e.ovf);
                idx++;
                ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom); rs = 1'($urandom);
            end
            cyc++;
        end
        chk("stream_accepted", idx, 6);
        @(posedge CLK);
        #1;
        IN_VALID  = 1'b0;
        OUT_READY = 1'b1;
        drain("drain_stream");

        // Reset between edges with two beats in flight.
        send(8'h01, 8'h02, 1'b0, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0);
        send(8'h10, 8'h20, 1'b0, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0);
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        chk("inflight_valid", OUT_VALID, 1);
        #1;
        RST_N = 1'b0;
        #1;
        chk("midrst_out_valid", OUT_VALID, 0);
        chk("midrst_f", F, 0);
        chk("midrst_c1_ovf", {C1, OVF}, 0);
        sb.delete();
        @(negedge CLK);
        RST_N = 1'b1;

        send(8'h22, 8'h11, 1'b1, 1'b0, 1'b0, 8'h34, 1'b0, 1'b0);
        idle();
        @(negedge CLK);
        chk("latency_cycle1", OUT_VALID, 0);
        @(negedge CLK);
        chk("latency_cycle2", OUT_VALID, 1);
        drain("drain_after_reset");

`ifdef ADDER_PIPE_SAT_EN
        send(8'h7F, 8'h01, 1'b0, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1);
        send(8'h80, 8'h01, 1'b0, 1'b1, 1'b1, 8'h80, 1'b1, 1'b1);
        send(8'h80, 8'hFF, 1'b0, 1'b0, 1'b1, 8'h80, 1'b1, 1'b1);
        send(8'h10, 8'h20, 1'b0, 1'b0, 1'b1, 8'h30, 1'b0, 1'b0);
        send(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        send(8'h80, 8'h01, 1'b0, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1);
        idle();
        drain("drain_sat");
`endif

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
